// File: rtl/board_controller.sv
// Game-flow controller for a sliding-tile board: sequences clear, spawn and move handshakes and judges win/lose.
// Optional handshake watchdog and sticky err output are enabled with macro BOARD_CTRL_TIMEOUT_EN.
module board_controller #(
  parameter int N        = 4,
  parameter int CW       = 4,
  parameter int WIN_CODE = 11,
  parameter int TIMEOUT  = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        direction,
  input  logic [N*N*CW-1:0] board_q,
  output logic              move_req,
  output logic [3:0]        move_dir,
  input  logic              move_done,
  input  logic              moved,
  output logic              spawn_req,
  input  logic              spawn_done,
  output logic              load,
  output logic              load_sel,
  output logic              clear_board,
  output logic [1:0]        endstatus,
  output logic              busy
`ifdef BOARD_CTRL_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, SPAWN1, SPAWN2, WAIT, MOVE, SPAWN, CHECK, WIN, LOSE
  } state_t;

  state_t     state, state_next;
  logic [3:0] direction_p1;
  logic       accept;
  logic       win, lose;
  logic       expired;

  function automatic logic [CW-1:0] cell_at(input logic [N*N*CW-1:0] b, input int idx);
    return b[(N*N-1-idx)*CW +: CW];
  endfunction

  // Board judgement; only consumed while in CHECK, one cycle after the load.
  always_comb begin
    win  = 1'b0;
    lose = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (cell_at(board_q, r*N + c) == CW'(WIN_CODE)) win = 1'b1;
        if (cell_at(board_q, r*N + c) == '0) lose = 1'b0;
        if (c < N-1) begin
          if (cell_at(board_q, r*N + c) == cell_at(board_q, r*N + c + 1)) lose = 1'b0;
        end
        if (r < N-1) begin
          if (cell_at(board_q, r*N + c) == cell_at(board_q, (r+1)*N + c)) lose = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_sel   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: state_next = IDLE;
      CLEAR: state_next = SPAWN1;
      SPAWN1, SPAWN2, SPAWN: begin
        if (spawn_done) begin
          load       = 1'b1;
          load_sel   = 1'b1;
          state_next = (state == SPAWN1) ? SPAWN2 : CHECK;
        end else if (expired) begin
          state_next = (state == SPAWN) ? WAIT : IDLE;
        end
      end
      WAIT: begin
        // Only a fresh 0000 -> one-hot transition counts as a move.
        if (direction_p1 == 4'b0000 && $onehot(direction)) begin
          accept     = 1'b1;
          state_next = MOVE;
        end
      end
      MOVE: begin
        if (move_done) begin
          load       = 1'b1;
          state_next = moved ? SPAWN : WAIT;
        end else if (expired) begin
          state_next = WAIT;
        end
      end
      CHECK: begin
        if (win)       state_next = WIN;
        else if (lose) state_next = LOSE;
        else           state_next = WAIT;
      end
      WIN, LOSE: state_next = state;
      default: state_next = IDLE;
    endcase
    // A new-game request overrides everything, including a pending load.
    if (start) begin
      state_next = CLEAR;
      load       = 1'b0;
      load_sel   = 1'b0;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      direction_p1 <= 4'b0000;
      move_dir     <= 4'b0000;
      endstatus    <= 2'b00;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      direction_p1 <= direction;
      if (accept) move_dir <= direction;
      endstatus    <= (state_next == WIN)  ? 2'b01 :
                      (state_next == LOSE) ? 2'b10 : 2'b00;
      busy         <= !(state_next inside {WAIT, WIN, LOSE});
    end
  end

  assign move_req    = (state == MOVE);
  assign spawn_req   = (state inside {SPAWN1, SPAWN2, SPAWN});
  assign clear_board = (state == CLEAR);

`ifdef BOARD_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          done_here;

  assign done_here = (state == MOVE) ? move_done : spawn_done;
  assign expired   = (state inside {MOVE, SPAWN1, SPAWN2, SPAWN}) && !done_here &&
                     (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if ((state_next == state) && (state inside {MOVE, SPAWN1, SPAWN2, SPAWN}))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (start)        err <= 1'b0;
      else if (expired) err <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: game start, move acceptance, spawn, win/lose judgement, abort, reset, watchdog.
`timescale 1ns/1ps
module tb_board_controller;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int BW = N*N*CW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    direction = 4'b0000;
  logic [BW-1:0] board_q = '0;
  logic          move_req;
  logic [3:0]    move_dir;
  logic          move_done = 1'b0;
  logic          moved = 1'b0;
  logic          spawn_req;
  logic          spawn_done = 1'b0;
  logic          load, load_sel, clear_board;
  logic [1:0]    endstatus;
  logic          busy;
`ifdef BOARD_CTRL_TIMEOUT_EN
  logic          err;
`endif

  int total = 0;
  int bad   = 0;

  // {clear_board, spawn_req, move_req, load, load_sel, busy}
  wire [5:0] ctl = {clear_board, spawn_req, move_req, load, load_sel, busy};

  always #5 clock = ~clock;

`ifdef BOARD_CTRL_TIMEOUT_EN
  board_controller #(.N(N), .CW(CW), .WIN_CODE(11), .TIMEOUT(8)) dut (
`else
  board_controller #(.N(N), .CW(CW), .WIN_CODE(11), .TIMEOUT(255)) dut (
`endif
    .clock(clock), .reset_n(reset_n), .start(start), .direction(direction),
    .board_q(board_q), .move_req(move_req), .move_dir(move_dir),
    .move_done(move_done), .moved(moved), .spawn_req(spawn_req),
    .spawn_done(spawn_done), .load(load), .load_sel(load_sel),
    .clear_board(clear_board), .endstatus(endstatus), .busy(busy)
`ifdef BOARD_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BW-1:0] set_cell(input logic [BW-1:0] b, input int idx, input logic [CW-1:0] v);
    logic [BW-1:0] r;
    r = b;
    r[(N*N-1-idx)*CW +: CW] = v;
    return r;
  endfunction

  // Checkerboard of 1s and 2s: full, no equal neighbours.
  function automatic logic [BW-1:0] lose_board();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < N*N; i++)
      b = set_cell(b, i, (((i / N) + (i % N)) % 2 == 1) ? 4'd2 : 4'd1);
    return b;
  endfunction

  // Start a game; the second spawn loads board b. Ends just after entering the post-CHECK state.
  task automatic new_game(input logic [BW-1:0] b);
    start = 1'b1; tick();
    start = 1'b0; tick();
    spawn_done = 1'b1; tick();
    board_q = b; tick();
    spawn_done = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total++;
    if ({ctl, endstatus, move_dir} !== 12'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", {ctl, endstatus, move_dir}, 12'b0);
    end
  endtask

  task automatic test_new_game();
    @(negedge clock); reset_n = 1'b1;
    tick();
    total++; if (ctl !== 6'b000001) begin bad++; $display("FAIL idle_ctl: got %b want 000001", ctl); end
    tick();
    total++; if (ctl !== 6'b000001) begin bad++; $display("FAIL idle_hold: got %b want 000001", ctl); end
    start = 1'b1; tick(); start = 1'b0; #1;
    total++; if (ctl !== 6'b100001) begin bad++; $display("FAIL clear_ctl: got %b want 100001", ctl); end
    tick();
    total++; if (ctl !== 6'b010001) begin bad++; $display("FAIL spawn1_ctl: got %b want 010001", ctl); end
    tick(); tick();
    total++; if (ctl !== 6'b010001) begin bad++; $display("FAIL spawn1_hold: got %b want 010001", ctl); end
    spawn_done = 1'b1; #1;
    total++; if (ctl !== 6'b010111) begin bad++; $display("FAIL spawn1_load: got %b want 010111", ctl); end
    tick(); spawn_done = 1'b0; #1;
    total++; if (ctl !== 6'b010001) begin bad++; $display("FAIL spawn2_ctl: got %b want 010001", ctl); end
    tick(); tick();
    spawn_done = 1'b1; #1;
    total++; if (ctl !== 6'b010111) begin bad++; $display("FAIL spawn2_load: got %b want 010111", ctl); end
    tick(); spawn_done = 1'b0; #1;
    total++; if ({ctl, endstatus} !== 8'b000001_00) begin bad++; $display("FAIL check_ctl: got %b want 00000100", {ctl, endstatus}); end
    tick();
    total++; if ({ctl, endstatus} !== 8'b000000_00) begin bad++; $display("FAIL wait_ctl: got %b want 00000000", {ctl, endstatus}); end
  endtask

  task automatic test_direction();
    int rises;
    logic prev;
    direction = 4'b0100; #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL accept_comb: got %b want 000000", ctl); end
    tick();
    total++; if (move_dir !== 4'b0100) begin bad++; $display("FAIL move_dir: got %b want 0100", move_dir); end
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (move_req && !prev) rises++;
      prev = move_req;
      if (i == 2) begin
        move_done = 1'b1; moved = 1'b0; #1;
        total++; if (ctl !== 6'b001101) begin bad++; $display("FAIL move_load_nomove: got %b want 001101", ctl); end
      end
      tick();
      move_done = 1'b0;
    end
    total++; if (rises !== 1) begin bad++; $display("FAIL held_dir_episodes: got %0d want 1", rises); end
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL back_to_wait: got %b want 000000", ctl); end
    direction = 4'b0000; tick();
    direction = 4'b0110; tick(); tick();
    total++; if ({ctl, move_dir} !== 10'b000000_0100) begin bad++; $display("FAIL multihot_ignored: got %b want 0000000100", {ctl, move_dir}); end
    direction = 4'b0000; tick();
  endtask

  task automatic test_move_spawn_win();
    direction = 4'b1000; tick();
    direction = 4'b0000;
    total++; if ({ctl, move_dir} !== 10'b001001_1000) begin bad++; $display("FAIL move2_start: got %b want 0010011000", {ctl, move_dir}); end
    move_done = 1'b1; moved = 1'b1; #1;
    total++; if (ctl !== 6'b001101) begin bad++; $display("FAIL move_load_moved: got %b want 001101", ctl); end
    tick(); move_done = 1'b0; moved = 1'b0; #1;
    total++; if (ctl !== 6'b010001) begin bad++; $display("FAIL spawn_after_move: got %b want 010001", ctl); end
    spawn_done = 1'b1; board_q = set_cell('0, 5, 4'd11); #1;
    total++; if (ctl !== 6'b010111) begin bad++; $display("FAIL spawn_load: got %b want 010111", ctl); end
    tick(); spawn_done = 1'b0; #1;
    total++; if ({ctl, endstatus} !== 8'b000001_00) begin bad++; $display("FAIL win_check: got %b want 00000100", {ctl, endstatus}); end
    tick();
    total++; if ({ctl, endstatus} !== 8'b000000_01) begin bad++; $display("FAIL win_status: got %b want 00000001", {ctl, endstatus}); end
    direction = 4'b0001; tick(); tick();
    total++; if ({ctl, endstatus} !== 8'b000000_01) begin bad++; $display("FAIL win_holds: got %b want 00000001", {ctl, endstatus}); end
    direction = 4'b0000; tick();
  endtask

  task automatic test_lose();
    start = 1'b1; tick(); start = 1'b0; #1;
    total++; if ({clear_board, endstatus} !== 3'b1_00) begin bad++; $display("FAIL start_clears_status: got %b want 100", {clear_board, endstatus}); end
    new_game(lose_board());
    total++; if ({ctl, endstatus} !== 8'b000000_10) begin bad++; $display("FAIL lose_status: got %b want 00000010", {ctl, endstatus}); end
    direction = 4'b0010; tick(); tick();
    total++; if ({move_req, endstatus} !== 3'b0_10) begin bad++; $display("FAIL lose_holds: got %b want 010", {move_req, endstatus}); end
    direction = 4'b0000;
    new_game(set_cell(lose_board(), 5, 4'd11));
    total++; if ({ctl, endstatus} !== 8'b000000_01) begin bad++; $display("FAIL win_over_lose: got %b want 00000001", {ctl, endstatus}); end
  endtask

  task automatic test_abort();
    new_game('0);
    total++; if ({ctl, endstatus} !== 8'b0) begin bad++; $display("FAIL empty_board_wait: got %b want 00000000", {ctl, endstatus}); end
    direction = 4'b0010; tick(); direction = 4'b0000;
    total++; if (move_req !== 1'b1) begin bad++; $display("FAIL abort_move_req: got %b want 1", move_req); end
    start = 1'b1; tick(); start = 1'b0; #1;
    total++; if (ctl !== 6'b100001) begin bad++; $display("FAIL abort_clear: got %b want 100001", ctl); end
    move_done = 1'b1; moved = 1'b1; tick();
    total++; if (ctl !== 6'b010001) begin bad++; $display("FAIL stray_done_spawn1: got %b want 010001", ctl); end
    tick(); move_done = 1'b0; moved = 1'b0; #1;
    total++; if (ctl !== 6'b010001) begin bad++; $display("FAIL stray_done_hold: got %b want 010001", ctl); end
    spawn_done = 1'b1; tick(); tick(); spawn_done = 1'b0; tick();
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL abort_new_game: got %b want 000000", ctl); end
    move_done = 1'b1; #1;
    total++; if (load !== 1'b0) begin bad++; $display("FAIL stray_done_wait_load: got %b want 0", load); end
    tick(); move_done = 1'b0; #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL stray_done_wait_state: got %b want 000000", ctl); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; tick(); start = 1'b0; tick();
    spawn_done = 1'b1; #1;
    total++; if (ctl !== 6'b010111) begin bad++; $display("FAIL pre_reset_load: got %b want 010111", ctl); end
    reset_n = 1'b0; #1;
    total++; if ({ctl, endstatus} !== 8'b0) begin bad++; $display("FAIL mid_reset_drop: got %b want 00000000", {ctl, endstatus}); end
    spawn_done = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    tick(); tick();
    total++; if (ctl !== 6'b000001) begin bad++; $display("FAIL post_reset_idle: got %b want 000001", ctl); end
  endtask

  task automatic test_timeout();
    int cnt;
    new_game('0);
    direction = 4'b0001; tick(); direction = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 20 && move_req; i++) begin
      cnt++;
      tick();
    end
`ifdef BOARD_CTRL_TIMEOUT_EN
    total++; if (cnt !== 8) begin bad++; $display("FAIL move_timeout_cycles: got %0d want 8", cnt); end
    total++; if ({ctl, err} !== 7'b000000_1) begin bad++; $display("FAIL move_timeout_wait_err: got %b want 0000001", {ctl, err}); end
    start = 1'b1; tick(); start = 1'b0; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", err); end
    tick();
    cnt = 0;
    for (int i = 0; i < 20 && spawn_req; i++) begin
      cnt++;
      tick();
    end
    total++; if (cnt !== 8) begin bad++; $display("FAIL spawn1_timeout_cycles: got %0d want 8", cnt); end
    total++; if ({ctl, err} !== 7'b000001_1) begin bad++; $display("FAIL spawn1_timeout_idle: got %b want 0000011", {ctl, err}); end
`else
    total++; if (cnt !== 20 || move_req !== 1'b1) begin bad++; $display("FAIL move_waits: got %0d/%b want 20/1", cnt, move_req); end
    move_done = 1'b1; moved = 1'b0; tick(); move_done = 1'b0; #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL late_done_wait: got %b want 000000", ctl); end
`endif
  endtask

  initial begin
    test_reset();
    test_new_game();
    test_direction();
    test_move_spawn_win();
    test_lose();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
